lane_select: RTL

LANE_SELECT -- requirements
Module: lane_select

---
 rtl/lane_pkg.sv | 21 ++
 rtl/key_repeat.sv | 94 +++++++++
 rtl/lane_select.sv | 100 ++++++++++
 3 files changed

// File: rtl/lane_pkg.sv
// Shared types and encodings for the lane selector and its key-repeat front end.
package lane_pkg;

    // Auto-repeat state machine states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Move request encodings on ctl (2'b11 is treated as no request)
    localparam logic [1:0] CTL_NONE = 2'b00;
    localparam logic [1:0] CTL_DEC  = 2'b01;
    localparam logic [1:0] CTL_INC  = 2'b10;

    // True when ctl carries a real move request in either direction
    function automatic logic is_move(input logic [1:0] ctl);
        is_move = (ctl == CTL_DEC) || (ctl == CTL_INC);
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Press detection and typematic auto-repeat: turns a held ctl level into
// single-cycle step pulses (first step at once, then delay, then period).
module key_repeat
    import lane_pkg::*;
#(
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ctl,
    output logic       step_dec,
    output logic       step_inc
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

    rep_state_e       state_r;
    rep_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [1:0]       ctl_prev_r;
    logic             move_s;
    logic             new_press_s;
    logic             step_s;

    assign move_s      = is_move(ctl);
    assign new_press_s = move_s && (ctl != ctl_prev_r);

    // Next-state, counter and step decision for the repeat machine
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (new_press_s) begin
                    step_s      = 1'b1;
                    state_nxt_s = DELAY;
                    cnt_nxt_s   = DELAY_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            DELAY, REPEAT: begin
                if (!move_s) begin
                    // Release (00 or 11) aborts the repeat without a step
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (new_press_s) begin
                    // Direct reversal restarts the whole sequence
                    step_s      = 1'b1;
                    state_nxt_s = DELAY;
                    cnt_nxt_s   = DELAY_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    step_s      = 1'b1;
                    state_nxt_s = REPEAT;
                    cnt_nxt_s   = PERIOD_LOAD;
                end else begin
                    state_nxt_s = state_r;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and previous-ctl registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= CNT_ZERO;
            ctl_prev_r <= CTL_NONE;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ctl_prev_r <= ctl;
        end
    end

    assign step_dec = step_s && (ctl == CTL_DEC);
    assign step_inc = step_s && (ctl == CTL_INC);

endmodule

// File: rtl/lane_select.sv
// Lane selector: holds the current lane, applies wrap/saturate stepping
// and presents registered one-hot, binary and moved outputs.
module lane_select
    import lane_pkg::*;
#(
    parameter int NUM_LANES     = 3,
    parameter int RESET_LANE    = 1,
    parameter int WRAP          = 0,
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   ctl,
    output logic [NUM_LANES-1:0]         aim,
    output logic [$clog2(NUM_LANES)-1:0] lane,
    output logic                         moved
);

    localparam int LW = $clog2(NUM_LANES);

    localparam logic [LW-1:0] LANE_FIRST = {LW{1'b0}};
    localparam logic [LW-1:0] LANE_LAST  = LW'(NUM_LANES - 1);
    localparam logic [LW-1:0] LANE_RST   = LW'(RESET_LANE);
    localparam logic [LW-1:0] LANE_ONE   = LW'(32'd1);
    localparam bit            WRAP_EN    = (WRAP != 32'sd0);

    logic [LW-1:0]        lane_r;
    logic [LW-1:0]        lane_nxt_s;
    logic [NUM_LANES-1:0] aim_r;
    logic                 moved_r;
    logic                 step_dec_s;
    logic                 step_inc_s;

    // One-hot decode of a lane index
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LW-1:0] idx);
        logic [NUM_LANES-1:0] oh;
        for (int i = 0; i < NUM_LANES; i++) begin
            oh[i] = (idx == LW'(i));
        end
        return oh;
    endfunction

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_key_repeat (
        .clk      (clk),
        .rst      (rst),
        .ctl      (ctl),
        .step_dec (step_dec_s),
        .step_inc (step_inc_s)
    );

    // Next lane: step down/up with wrap or saturation at the end lanes
    always_comb begin
        lane_nxt_s = lane_r;
        if (step_dec_s) begin
            if (lane_r == LANE_FIRST) begin
                if (WRAP_EN) begin
                    lane_nxt_s = LANE_LAST;
                end else begin
                    lane_nxt_s = lane_r;
                end
            end else begin
                lane_nxt_s = lane_r - LANE_ONE;
            end
        end else if (step_inc_s) begin
            if (lane_r >= LANE_LAST) begin
                if (WRAP_EN) begin
                    lane_nxt_s = LANE_FIRST;
                end else begin
                    lane_nxt_s = LANE_LAST;
                end
            end else begin
                lane_nxt_s = lane_r + LANE_ONE;
            end
        end else begin
            lane_nxt_s = lane_r;
        end
    end

    // Lane register with its one-hot copy and the change pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r  <= LANE_RST;
            aim_r   <= lane_onehot(LANE_RST);
            moved_r <= 1'b0;
        end else begin
            lane_r  <= lane_nxt_s;
            aim_r   <= lane_onehot(lane_nxt_s);
            moved_r <= (lane_nxt_s != lane_r);
        end
    end

    assign lane  = lane_r;
    assign aim   = aim_r;
    assign moved = moved_r;

endmodule
